segment_chaser_pwm: RTL and testbench
=====================================

Name: segment_chaser_pwm

Overview:
- Parametrised LED/segment chaser with PWM fade tail. A single "head" walks a programmable sequence of output channels; previously lit channels decay in brightness.
- Generalises the fixed 7-segment figure-8 spinner to N channels, an arbitrary step map, configurable brightness depth and four run modes: wrap, bounce, hold, one-shot.
- Sits directly on the user I/O pins. All outputs are registered.

Parameters:
NUM_CH, 8, number of LED output channels (2..16)
CH_IDX_W, 3, bits per map entry; must hold NUM_CH-1
SEQ_LEN, 8, steps in the sequence (2..16)
SEQ_MAP, 24'o56234610, packed channel index per step, step 0 in LSBs; default is the figure-8 order 0,1,6,4,3,2,6,5
LEVEL_W, 4, brightness bits per channel
STEP_W, 12, step-period timer width
FADE_DIV_W, 8, fade tick occurs every 2^FADE_DIV_W clocks

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = step timer and position run
speed  in  STEP_W  step period minus 1, in clocks
mode  in  2  00 wrap, 01 bounce, 10 hold, 11 one-shot
dir  in  1  1 = forward (increasing step), 0 = backward
tail  in  1  1 = fading tail, 0 = head only
invert  in  1  1 = invert all led_out bits
led_out  out  NUM_CH  PWM LED drive
step_idx  out  clog2(SEQ_LEN)  current sequence position
wrap_pulse  out  1  one-clock pulse on wrap, reversal or one-shot end
done  out  1  one-shot complete (sticky)

Behaviour:
- Reset (async): all registers clear to 0. This gives led_out=0, step_idx=0, wrap_pulse=0, done=0, all levels=0 and all counters=0. Outputs go to 0 without a clock edge.
- Config registers: speed, mode, dir, tail, invert are registered every clk. All logic uses the registered copies, so config changes take effect after 1 clock.
- Step timer: counts 0..speed_r.
  - When timer >= speed_r: timer goes to 0 and a step event fires. speed_r=0 gives a step event every clock.
  - Timer is frozen when enable=0 or mode=hold.
- Position update on a step event:
  - Wrap: dir=1 gives pos+1 with SEQ_LEN-1 -> 0. dir=0 gives pos-1 with 0 -> SEQ_LEN-1. wrap_pulse fires on the wrap transition.
  - Bounce: uses an internal bdir register. bdir is loaded from dir_r on every clock while mode_r != bounce. At SEQ_LEN-1 going forward, or 0 going backward, bdir flips and pos moves one step the other way (no dwell). wrap_pulse fires on each reversal.
  - Hold: pos is frozen. Fade and PWM continue.
  - One-shot: moves like wrap, except at the step that would wrap, pos stays put, done is set and wrap_pulse fires once. Further step events are ignored while done=1. done clears on the clock after mode_r leaves one-shot. pos is not reset.
  - wrap_pulse is high for exactly one clock per qualifying event and 0 otherwise.
- Levels: one LEVEL_W register per channel.
  - Head channel is SEQ_MAP[pos]. Its level is forced to all-ones (2^LEVEL_W-1) every clock; the head override wins over any fade.
  - Map entries >= NUM_CH light nothing.
  - Non-head channels with tail_r=0: level goes to 0.
  - Non-head channels with tail_r=1: on each fade tick, level = level >> 1. The fade tick is a free-running FADE_DIV_W counter == 0, independent of the step timer and of enable.
  - A channel that appears twice in the map behaves normally; it is simply head on two steps.
- PWM:
  - pwm_cnt is a free-running LEVEL_W counter.
  - led_raw[c] = (level[c] > pwm_cnt), registered.
  - led_out = led_raw_reg XOR {NUM_CH{invert_r}}.
  - Duty cycle = level/2^LEVEL_W, so a full-on head gives 15/16 at LEVEL_W=4.
- Latency: pos change at edge k, head level at edge k+1, led_out change at edge k+2 (subject to the PWM phase).
- Reset mid-run: state is lost and the block restarts from pos 0 on the first clock after reset deasserts.

Test Plan:
- Async reset: assert reset between clk edges during a run -> led_out=0, step_idx=0, done=0 immediately; after release, pos=0 head is channel 0.
- Wrap forward: mode=00, dir=1, speed=3, tail=0, enable=1 -> step_idx advances every 4 clocks 0..7,0; wrap_pulse is one clock at the 7->0 step. Only channel SEQ_MAP[pos] toggles, at 15/16 duty, in order 0,1,6,4,3,2,6,5.
- Wrap backward / enable: dir=0 from pos 0 -> 7, wrap_pulse once. Drop enable for 20 clocks -> step_idx holds and the head LED keeps PWM.
- Bounce: mode=01, dir=1, speed=0 -> step_idx sequence 0..7,6..0,1; wrap_pulse exactly at the 7->6 and 0->1 steps.
- One-shot: mode=11, dir=1, speed=0 from pos 5 -> 6, 7, then hold at 7 with done=1 and wrap_pulse high for one clock. Switch mode to 00 -> done=0 the next clock after the registered mode updates, and stepping resumes 7->0.
- Tail/invert: FADE_DIV_W=2, tail=1, speed large, head moves off channel c -> level[c] follows 15, 7, 3, 1, 0 on successive fade ticks (duty 7/16, 3/16, 1/16, 0). invert=1 -> every led_out bit is complemented; during reset led_out=0.

Source files
------------

// File: rtl/segment_chaser_pwm.sv
// Chaser whose head walks a programmable channel map. Channels the head has left
// fade out through a binary-decay tail, and each channel drives its pin with PWM.

module segment_chaser_ch #(
  parameter int LEVEL_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               is_head,
  input  logic               tail,
  input  logic               fade_tick,
  input  logic [LEVEL_W-1:0] pwm_cnt,
  output logic               led_raw
);
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               led_raw_q, led_raw_d;

  // When a channel is the head, it is forced to full scale and no fading applies.
  always_comb begin
    level_d = level_q;
    if (is_head)        level_d = '1;
    else if (!tail)     level_d = '0;
    else if (fade_tick) level_d = level_q >> 1;
    led_raw_d = (level_q > pwm_cnt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q   <= '0;
      led_raw_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      led_raw_q <= led_raw_d;
    end
  end

  assign led_raw = led_raw_q;
endmodule

module segment_chaser_pwm #(
  parameter int                          NUM_CH     = 8,
  parameter int                          CH_IDX_W   = 3,
  parameter int                          SEQ_LEN    = 8,
  parameter logic [SEQ_LEN*CH_IDX_W-1:0] SEQ_MAP    = 24'o56234610,
  parameter int                          LEVEL_W    = 4,
  parameter int                          STEP_W     = 12,
  parameter int                          FADE_DIV_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [STEP_W-1:0]          speed,
  input  logic [1:0]                 mode,
  input  logic                       dir,
  input  logic                       tail,
  input  logic                       invert,
  output logic [NUM_CH-1:0]          led_out,
  output logic [$clog2(SEQ_LEN)-1:0] step_idx,
  output logic                       wrap_pulse,
  output logic                       done
);
  localparam int               POS_W = $clog2(SEQ_LEN);
  localparam logic [POS_W-1:0] LAST  = POS_W'(SEQ_LEN - 1);

  typedef enum logic [1:0] {M_WRAP, M_BOUNCE, M_HOLD, M_ONESHOT} mode_e;

  logic [STEP_W-1:0]     speed_q, timer_q, timer_d;
  mode_e                 mode_q;
  logic                  dir_q, tail_q, invert_q;
  logic [POS_W-1:0]      pos_q, pos_d, pos_inc, pos_dec;
  logic                  bdir_q, bdir_d, done_q, done_d, wrap_q, wrap_d;
  logic [FADE_DIV_W-1:0] fade_cnt_q, fade_cnt_d;
  logic [LEVEL_W-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic                  run, step_evt, at_end;
  logic [CH_IDX_W-1:0]   head_ch;
  logic [NUM_CH-1:0]     led_raw;

  always_comb begin
    run        = enable && (mode_q != M_HOLD);
    step_evt   = run && (timer_q >= speed_q);
    timer_d    = step_evt ? '0 : (run ? timer_q + 1'b1 : timer_q);
    fade_cnt_d = fade_cnt_q + 1'b1;
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    pos_inc    = (pos_q == LAST) ? '0 : pos_q + 1'b1;
    pos_dec    = (pos_q == '0) ? LAST : pos_q - 1'b1;
    at_end     = dir_q ? (pos_q == LAST) : (pos_q == '0);
    pos_d      = pos_q;
    bdir_d     = (mode_q == M_BOUNCE) ? bdir_q : dir_q;
    done_d     = (mode_q == M_ONESHOT) ? done_q : 1'b0;
    wrap_d     = 1'b0;
    if (step_evt) begin
      case (mode_q)
        M_WRAP: begin
          pos_d  = dir_q ? pos_inc : pos_dec;
          wrap_d = at_end;
        end
        M_BOUNCE: begin
          // Reversal moves straight back one step rather than dwelling at the end.
          if (bdir_q ? (pos_q == LAST) : (pos_q == '0)) begin
            bdir_d = ~bdir_q;
            wrap_d = 1'b1;
            pos_d  = bdir_q ? pos_q - 1'b1 : pos_q + 1'b1;
          end else begin
            pos_d  = bdir_q ? pos_q + 1'b1 : pos_q - 1'b1;
          end
        end
        M_ONESHOT: begin
          if (!done_q) begin
            if (at_end) begin
              done_d = 1'b1;
              wrap_d = 1'b1;
            end else begin
              pos_d  = dir_q ? pos_inc : pos_dec;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      speed_q    <= '0;
      mode_q     <= M_WRAP;
      dir_q      <= 1'b0;
      tail_q     <= 1'b0;
      invert_q   <= 1'b0;
      timer_q    <= '0;
      pos_q      <= '0;
      bdir_q     <= 1'b0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
      fade_cnt_q <= '0;
      pwm_cnt_q  <= '0;
    end else begin
      speed_q    <= speed;
      mode_q     <= mode_e'(mode);
      dir_q      <= dir;
      tail_q     <= tail;
      invert_q   <= invert;
      timer_q    <= timer_d;
      pos_q      <= pos_d;
      bdir_q     <= bdir_d;
      done_q     <= done_d;
      wrap_q     <= wrap_d;
      fade_cnt_q <= fade_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
    end
  end

  assign head_ch = SEQ_MAP[int'(pos_q) * CH_IDX_W +: CH_IDX_W];

  // A map entry that is NUM_CH or higher does not match any lane, so no channel lights.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    segment_chaser_ch #(.LEVEL_W(LEVEL_W)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .is_head  (head_ch == CH_IDX_W'(c)),
      .tail     (tail_q),
      .fade_tick(fade_cnt_q == '0),
      .pwm_cnt  (pwm_cnt_q),
      .led_raw  (led_raw[c])
    );
  end

  assign led_out    = led_raw ^ {NUM_CH{invert_q}};
  assign step_idx   = pos_q;
  assign wrap_pulse = wrap_q;
  assign done       = done_q;
endmodule

// File: tb/tb_segment_chaser_pwm.sv
// Bench for segment_chaser_pwm: directed vector table, hand sequences, and random
// stimulus compared against a cycle model written in plain integer arithmetic.

module tb_segment_chaser_pwm;
  localparam int NUM_CH = 8;
  localparam int SEQ_LEN = 8;
  localparam int STEP_W = 12;
  localparam int FADE = 4;   // 2^FADE_DIV_W
  localparam int PWM = 16;   // 2^LEVEL_W

  logic clk = 1'b0, reset = 1'b0, enable = 1'b0, dir = 1'b0, tail = 1'b0, invert = 1'b0;
  logic [STEP_W-1:0] speed = '0;
  logic [1:0] mode = 2'd0;
  logic [NUM_CH-1:0] led_out;
  logic [2:0] step_idx;
  logic wrap_pulse, done;

  int total = 0, bad = 0;
  int duty [NUM_CH];

  segment_chaser_pwm #(.FADE_DIV_W(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .speed(speed), .mode(mode), .dir(dir),
    .tail(tail), .invert(invert), .led_out(led_out), .step_idx(step_idx),
    .wrap_pulse(wrap_pulse), .done(done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int map [SEQ_LEN] = '{0, 1, 6, 4, 3, 2, 6, 5};
  int m_speed, m_mode, m_timer, m_pos, m_n;
  bit m_dir, m_tail, m_inv, m_bdir, m_done, m_wrap;
  int m_level [NUM_CH];
  bit m_raw [NUM_CH];

  task automatic model_reset();
    m_speed = 0; m_mode = 0; m_timer = 0; m_pos = 0; m_n = 0;
    m_dir = 0; m_tail = 0; m_inv = 0; m_bdir = 0; m_done = 0; m_wrap = 0;
    for (int c = 0; c < NUM_CH; c++) begin m_level[c] = 0; m_raw[c] = 0; end
  endtask

  task automatic model_step();
    int head, d, nxt;
    bit run, ev, tick;
    head = map[m_pos];
    tick = (m_n % FADE) == 0;
    for (int c = 0; c < NUM_CH; c++) m_raw[c] = m_level[c] > (m_n % PWM);
    for (int c = 0; c < NUM_CH; c++)
      if (c == head) m_level[c] = PWM - 1;
      else if (!m_tail) m_level[c] = 0;
      else if (tick) m_level[c] = m_level[c] / 2;
    run = enable && (m_mode != 2);
    ev = run && (m_timer >= m_speed);
    m_timer = ev ? 0 : (run ? m_timer + 1 : m_timer);
    m_wrap = 0;
    if (m_mode != 1) m_bdir = m_dir;
    if (m_mode != 3) m_done = 0;
    if (ev) begin
      case (m_mode)
        0: begin
          nxt = m_pos + (m_dir ? 1 : -1);
          m_wrap = (nxt < 0) || (nxt >= SEQ_LEN);
          m_pos = (nxt + SEQ_LEN) % SEQ_LEN;
        end
        1: begin
          d = m_bdir ? 1 : -1;
          nxt = m_pos + d;
          if (nxt < 0 || nxt >= SEQ_LEN) begin
            m_bdir = !m_bdir; m_wrap = 1; nxt = m_pos - d;
          end
          m_pos = nxt;
        end
        3: if (!m_done) begin
          nxt = m_pos + (m_dir ? 1 : -1);
          if (nxt < 0 || nxt >= SEQ_LEN) begin m_done = 1; m_wrap = 1; end
          else m_pos = nxt;
        end
        default: ;
      endcase
    end
    m_speed = int'(speed); m_mode = int'(mode); m_dir = dir; m_tail = tail; m_inv = invert;
    m_n++;
  endtask

  always @(posedge clk or posedge reset)
    if (reset) model_reset(); else model_step();

  function automatic logic [31:0] exp_vec();
    logic [NUM_CH-1:0] el;
    for (int c = 0; c < NUM_CH; c++) el[c] = m_raw[c] ^ m_inv;
    return {19'b0, el, 3'(m_pos), m_wrap, m_done};
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic run_cmp(input int n);
    repeat (n) begin
      step();
      chk("model", {19'b0, led_out, step_idx, wrap_pulse, done}, exp_vec());
    end
  endtask

  task automatic measure(input int n);
    for (int c = 0; c < NUM_CH; c++) duty[c] = 0;
    repeat (n) begin
      step();
      for (int c = 0; c < NUM_CH; c++) if (led_out[c]) duty[c]++;
    end
  endtask

  task automatic cfg(input logic en, input logic [1:0] md, input logic dr, input int spd,
                     input logic tl, input logic inv);
    enable = en; mode = md; dir = dr; speed = STEP_W'(spd); tail = tl; invert = inv;
  endtask

  typedef struct {
    logic [1:0] mode; logic dir; int speed; int n; int e_pos; bit e_done; int e_pulses;
  } vec_t;
  vec_t tbl [15];

  initial begin
    int pulses;
    tbl[0]  = '{2'd0, 1'b1, 3, 12, 3, 1'b0, 0};
    tbl[1]  = '{2'd0, 1'b1, 3, 32, 0, 1'b0, 1};
    tbl[2]  = '{2'd0, 1'b1, 0, 19, 3, 1'b0, 2};
    tbl[3]  = '{2'd0, 1'b0, 0, 1, 7, 1'b0, 1};
    tbl[4]  = '{2'd0, 1'b0, 2, 30, 6, 1'b0, 2};
    tbl[5]  = '{2'd1, 1'b1, 0, 7, 7, 1'b0, 0};
    tbl[6]  = '{2'd1, 1'b1, 0, 8, 6, 1'b0, 1};
    tbl[7]  = '{2'd1, 1'b1, 0, 15, 1, 1'b0, 2};
    tbl[8]  = '{2'd1, 1'b0, 0, 3, 3, 1'b0, 1};
    tbl[9]  = '{2'd2, 1'b1, 0, 10, 0, 1'b0, 0};
    tbl[10] = '{2'd3, 1'b1, 0, 7, 7, 1'b0, 0};
    tbl[11] = '{2'd3, 1'b1, 0, 20, 7, 1'b1, 1};
    tbl[12] = '{2'd3, 1'b0, 1, 10, 0, 1'b1, 1};
    tbl[13] = '{2'd0, 1'b1, 5, 5, 0, 1'b0, 0};
    tbl[14] = '{2'd0, 1'b1, 5, 6, 1, 1'b0, 0};

    // Reset state
    do_reset();
    chk("reset_outs", {19'b0, led_out, step_idx, wrap_pulse, done}, 32'd0);

    // Vector table: load dir in wrap mode, switch to target mode, then run N enabled clocks
    for (int i = 0; i < 15; i++) begin
      do_reset();
      cfg(1'b0, 2'd0, tbl[i].dir, tbl[i].speed, 1'b0, 1'b0);
      step();
      mode = tbl[i].mode;
      step();
      enable = 1'b1;
      pulses = 0;
      repeat (tbl[i].n) begin step(); if (wrap_pulse) pulses++; end
      chk($sformatf("vec%0d_pos", i), 32'(step_idx), 32'(tbl[i].e_pos));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].e_done));
      chk($sformatf("vec%0d_pulses", i), 32'(pulses), 32'(tbl[i].e_pulses));
    end

    // One-shot from pos 5, then leave one-shot
    do_reset();
    cfg(1'b0, 2'd0, 1'b1, 0, 1'b0, 1'b0);
    step();
    enable = 1'b1;
    repeat (5) step();
    chk("os_start", 32'(step_idx), 32'd5);
    enable = 1'b0; mode = 2'd3;
    step();
    enable = 1'b1;
    step(); chk("os_6", {29'b0, step_idx}, 32'd6);
    step(); chk("os_7", {29'b0, step_idx}, 32'd7);
    step(); chk("os_end", {28'b0, step_idx, wrap_pulse, done}, {28'b0, 3'd7, 1'b1, 1'b1});
    step(); chk("os_hold", {28'b0, step_idx, wrap_pulse, done}, {28'b0, 3'd7, 1'b0, 1'b1});
    mode = 2'd0;
    step(); chk("os_leave1", {28'b0, step_idx, wrap_pulse, done}, {28'b0, 3'd7, 1'b0, 1'b1});
    step(); chk("os_leave2", {28'b0, step_idx, wrap_pulse, done}, {28'b0, 3'd0, 1'b1, 1'b0});

    // Async reset between edges with invert active
    invert = 1'b1;
    step(); step();
    #2 reset = 1'b1;
    #1 chk("async_reset", {19'b0, led_out, step_idx, wrap_pulse, done}, 32'd0);
    @(negedge clk); reset = 1'b0;
    cfg(1'b0, 2'd0, 1'b1, 0, 1'b0, 1'b0);
    step(); step();
    measure(16);
    chk("rst_pos", 32'(step_idx), 32'd0);
    for (int c = 0; c < NUM_CH; c++) chk($sformatf("head0_duty%0d", c), 32'(duty[c]), (c == 0) ? 32'd15 : 32'd0);
    invert = 1'b1;
    step(); step();
    measure(16);
    for (int c = 0; c < NUM_CH; c++) chk($sformatf("inv_duty%0d", c), 32'(duty[c]), (c == 0) ? 32'd1 : 32'd16);

    // Enable drop holds position while head keeps PWM
    do_reset();
    cfg(1'b0, 2'd0, 1'b1, 3, 1'b0, 1'b0);
    step();
    enable = 1'b1;
    repeat (8) step();
    enable = 1'b0;
    repeat (20) step();
    chk("en_hold_pos", 32'(step_idx), 32'd2);
    measure(16);
    chk("en_hold_duty6", 32'(duty[6]), 32'd15);
    chk("en_hold_duty0", 32'(duty[0]), 32'd0);

    // Tail fade after head leaves channel 0
    do_reset();
    cfg(1'b0, 2'd0, 1'b1, 0, 1'b1, 1'b0);
    repeat (4) step();
    enable = 1'b1;
    step();
    enable = 1'b0;
    run_cmp(24);
    measure(16);
    chk("tail_duty0", 32'(duty[0]), 32'd0);
    chk("tail_duty1", 32'(duty[1]), 32'd15);

    // Random stimulus against the model
    do_reset();
    cfg(1'b1, 2'd0, 1'b1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 24) == 0) speed = STEP_W'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) tail = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) invert = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 7) != 0);
      run_cmp(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
